// File: rtl/cic_pool_flatten.sv
// cic_pool_flatten
//   Downstream stage of the CIC convolution engine. Once started, it reads
//   both Layer 0 kernel maps (IMG_W x IMG_W) from the shared result memory,
//   applies a 2x2 stride-2 max-pool, writes each pooled value to its Layer 1
//   map (L1K0/L1K1), and writes the same value to the interleaved Layer 2
//   flatten vector (L2F).
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous reset, active-low
//   start     one-cycle pulse; accepted only in IDLE
//   busy      high from the cycle after start is accepted until done
//   done      one-cycle pulse after the final write
//   crd       result-memory read enable
//   caddr_rd  read address
//   cdata_rd  read data, valid one clock after crd/caddr_rd
//   cwr       result-memory write enable
//   caddr_wr  write address
//   cdata_wr  write data
//   csel      memory select (0 none, 1 L0K0, 2 L0K1, 3 L1K0, 4 L1K1, 5 L2F)
module cic_pool_flatten #(
  parameter int DW    = 20,
  parameter int AW    = 12,
  parameter int IMG_W = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
);

  localparam int POOL_W = IMG_W / 2;
  localparam int CW     = $clog2(POOL_W);

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_L0K0 = 3'b001;
  localparam logic [2:0] SEL_L0K1 = 3'b010;
  localparam logic [2:0] SEL_L1K0 = 3'b011;
  localparam logic [2:0] SEL_L1K1 = 3'b100;
  localparam logic [2:0] SEL_L2F  = 3'b101;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_RD2,
    S_RD3,
    S_CAP,
    S_WR1,
    S_WR2,
    S_FIN
  } state_t;

  state_t          state;
  logic            kern;
  logic [CW-1:0]   py;
  logic [CW-1:0]   px;
  logic [DW-1:0]   mx;

  logic            px_last;
  logic            py_last;
  logic            all_done;
  logic [CW-1:0]   nx_px;
  logic [CW-1:0]   nx_py;
  logic            nx_kern;
  logic [AW-1:0]   base_cur;
  logic [AW-1:0]   base_nx;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   l2f_addr;
  logic [DW-1:0]   rd_max;

  always_comb begin
    px_last  = &px;
    py_last  = &py;
    all_done = kern & px_last & py_last;
    nx_px    = px + 1'b1;
    nx_py    = px_last ? py + 1'b1 : py;
    nx_kern  = (px_last & py_last) ? ~kern : kern;
    // Top-left of the window: (2py)*IMG_W + 2px, i.e. {py,0,px,0} since
    // IMG_W is a power of two.
    base_cur = AW'({py, 1'b0, px, 1'b0});
    base_nx  = AW'({nx_py, 1'b0, nx_px, 1'b0});
    wr_idx   = AW'({py, px});
    l2f_addr = {wr_idx[AW-2:0], kern};
    // Strict compare: on a tie the value already held is kept.
    rd_max   = (cdata_rd > mx) ? cdata_rd : mx;
  end

  // Outputs are registered and loaded together with the state they belong
  // to, so each branch sets up the next state's memory command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      kern     <= 1'b0;
      py       <= '0;
      px       <= '0;
      mx       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      crd      <= 1'b0;
      cwr      <= 1'b0;
      csel     <= SEL_NONE;
      caddr_rd <= '0;
      caddr_wr <= '0;
      cdata_wr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RD0;
            busy     <= 1'b1;
            crd      <= 1'b1;
            csel     <= kern ? SEL_L0K1 : SEL_L0K0;
            caddr_rd <= base_cur;
          end
        end
        S_RD0: begin
          state    <= S_RD1;
          caddr_rd <= base_cur + AW'(1);
        end
        S_RD1: begin
          state    <= S_RD2;
          mx       <= cdata_rd;
          caddr_rd <= base_cur + AW'(IMG_W);
        end
        S_RD2: begin
          state    <= S_RD3;
          mx       <= rd_max;
          caddr_rd <= base_cur + AW'(IMG_W + 1);
        end
        S_RD3: begin
          state <= S_CAP;
          mx    <= rd_max;
          crd   <= 1'b0;
          csel  <= SEL_NONE;
        end
        S_CAP: begin
          state    <= S_WR1;
          mx       <= rd_max;
          cwr      <= 1'b1;
          csel     <= kern ? SEL_L1K1 : SEL_L1K0;
          caddr_wr <= wr_idx;
          cdata_wr <= rd_max;
        end
        S_WR1: begin
          state    <= S_WR2;
          csel     <= SEL_L2F;
          caddr_wr <= l2f_addr;
        end
        S_WR2: begin
          cwr  <= 1'b0;
          px   <= nx_px;
          py   <= nx_py;
          kern <= nx_kern;
          if (all_done) begin
            state <= S_FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
            csel  <= SEL_NONE;
          end else begin
            state    <= S_RD0;
            crd      <= 1'b1;
            csel     <= nx_kern ? SEL_L0K1 : SEL_L0K0;
            caddr_rd <= base_nx;
          end
        end
        S_FIN: begin
          state    <= S_IDLE;
          done     <= 1'b0;
          caddr_rd <= '0;
          caddr_wr <= '0;
          cdata_wr <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cic_pool_flatten.sv
module tb_cic_pool_flatten;

  localparam int DW         = 20;
  localparam int AW         = 12;
  localparam int IMG_W      = 64;
  localparam int PW         = IMG_W / 2;
  localparam int NPIX       = IMG_W * IMG_W;
  localparam int NPOOL      = PW * PW;
  localparam int RUN_CYCLES = 2 * NPOOL * 7 + 1;
  localparam logic [DW-1:0] SENT = 20'hA5C3E;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, crd, cwr;
  logic [AW-1:0] caddr_rd, caddr_wr;
  logic [DW-1:0] cdata_rd = '0;
  logic [DW-1:0] cdata_wr;
  logic [2:0]    csel;

  always #5 clk = ~clk;

  cic_pool_flatten #(.DW(DW), .AW(AW), .IMG_W(IMG_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .csel     (csel)
  );

  logic [DW-1:0] l0  [2][NPIX];
  logic [DW-1:0] l1  [2][NPOOL];
  logic [DW-1:0] l2f [2*NPOOL];
  logic          clear_req = 1'b0;

  int rd_cnt = 0;
  int wr_cnt = 0;
  int viol   = 0;
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Result memory: synchronous read, write on the clock edge.
  always @(posedge clk) begin
    if (crd) begin
      if (csel == 3'd1)      cdata_rd <= l0[0][caddr_rd];
      else if (csel == 3'd2) cdata_rd <= l0[1][caddr_rd];
      else                   cdata_rd <= '1;
    end
    if (clear_req) begin
      for (int i = 0; i < NPOOL; i++) begin
        l1[0][i] <= SENT;
        l1[1][i] <= SENT;
      end
      for (int i = 0; i < 2*NPOOL; i++) l2f[i] <= SENT;
    end else if (cwr) begin
      case (csel)
        3'd3: l1[0][caddr_wr[9:0]] <= cdata_wr;
        3'd4: l1[1][caddr_wr[9:0]] <= cdata_wr;
        3'd5: l2f[caddr_wr[10:0]]  <= cdata_wr;
        default: ;
      endcase
    end
  end

  // Bus protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (crd) rd_cnt++;
    if (cwr) wr_cnt++;
    if (crd && cwr) viol++;
    else if (crd && !(csel == 3'd1 || csel == 3'd2)) viol++;
    else if (cwr && !(csel == 3'd3 || csel == 3'd4 || csel == 3'd5)) viol++;
    else if (!crd && !cwr && csel != 3'd0) viol++;
    if (cwr && (csel == 3'd3 || csel == 3'd4) && caddr_wr >= 12'd1024) viol++;
    if (cwr && csel == 3'd5 && caddr_wr >= 12'd2048) viol++;
  end

  function automatic logic [DW-1:0] pool_ref(input int k, input int py, input int px);
    int a;
    logic [DW-1:0] m;
    a = 2 * py * IMG_W + 2 * px;
    m = l0[k][a];
    if (l0[k][a+1] > m)       m = l0[k][a+1];
    if (l0[k][a+IMG_W] > m)   m = l0[k][a+IMG_W];
    if (l0[k][a+IMG_W+1] > m) m = l0[k][a+IMG_W+1];
    return m;
  endfunction

  task automatic check_results(input string tag);
    logic [DW-1:0] e;
    for (int k = 0; k < 2; k++)
      for (int py = 0; py < PW; py++)
        for (int px = 0; px < PW; px++) begin
          e = pool_ref(k, py, px);
          check($sformatf("%s_l1k%0d[%0d]", tag, k, py*PW+px), 64'(l1[k][py*PW+px]), 64'(e));
          check($sformatf("%s_l2f[%0d]", tag, (py*PW+px)*2+k), 64'(l2f[(py*PW+px)*2+k]), 64'(e));
        end
  endtask

  function automatic logic [63:0] outs();
    return 64'({busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr});
  endfunction

  task automatic do_run(input string tag, input int extra_start_at, input int abort_at);
    int cyc, rd0, wr0, v0, gap;
    clear_req = 1'b1;
    @(posedge clk);
    #1 clear_req = 1'b0;
    @(negedge clk);
    rd0 = rd_cnt; wr0 = wr_cnt; v0 = viol; gap = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    check({tag, "_busy_rise"}, 64'(busy), 64'd1);
    while (!done && cyc < RUN_CYCLES + 100) begin
      if (cyc == abort_at) break;
      if (cyc == extra_start_at) start = 1'b1;
      if (!busy) gap++;
      @(posedge clk);
      #1 start = 1'b0;
      cyc++;
    end
    if (cyc == abort_at) begin
      reset = 1'b0;
      #1;
      check({tag, "_reset_outs"}, outs(), 64'd0);
      wr0 = wr_cnt;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      check({tag, "_no_writes"}, 64'(wr_cnt), 64'(wr0));
      check({tag, "_idle_outs"}, outs(), 64'd0);
      return;
    end
    check({tag, "_done_cycle"}, 64'(cyc), 64'(RUN_CYCLES));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_busy_gap"}, 64'(gap), 64'd0);
    @(posedge clk);
    #1;
    check({tag, "_done_width"}, 64'(done), 64'd0);
    check({tag, "_reads"}, 64'(rd_cnt - rd0), 64'd8192);
    check({tag, "_writes"}, 64'(wr_cnt - wr0), 64'd4096);
    check({tag, "_protocol"}, 64'(viol - v0), 64'd0);
    check_results(tag);
  endtask

  initial begin
    int pos, a;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", outs(), 64'd0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("idle_outs", outs(), 64'd0);
    end

    for (int i = 0; i < NPIX; i++) begin
      l0[0][i] = DW'(i);
      l0[1][i] = DW'(4095 - i);
    end
    do_run("ramp", -1, -1);
    check("ramp_l1k0_0",    64'(l1[0][0]),      64'd65);
    check("ramp_l1k0_1023", 64'(l1[0][1023]),   64'd4095);
    check("ramp_l1k1_0",    64'(l1[1][0]),      64'd4095);
    // Descending ramp: the window maximum sits at its smallest address, 4030.
    check("ramp_l1k1_1023", 64'(l1[1][1023]),   64'd65);
    check("ramp_l2f_0",     64'(l2f[0]),        64'd65);
    check("ramp_l2f_1",     64'(l2f[1]),        64'd4095);
    check("ramp_l2f_2046",  64'(l2f[2046]),     64'd4095);
    check("ramp_l2f_2047",  64'(l2f[2047]),     64'd65);

    do_run("busy_start", 500, -1);
    check("busy_l2f_0",    64'(l2f[0]),    64'd65);
    check("busy_l2f_2046", 64'(l2f[2046]), 64'd4095);

    for (int k = 0; k < 2; k++)
      for (int py = 0; py < PW; py++)
        for (int px = 0; px < PW; px++) begin
          a = 2 * py * IMG_W + 2 * px;
          l0[k][a] = 20'd5; l0[k][a+1] = 20'd5;
          l0[k][a+IMG_W] = 20'd5; l0[k][a+IMG_W+1] = 20'd5;
          pos = (py * PW + px + k) % 4;
          l0[k][a + (pos / 2) * IMG_W + (pos % 2)] = 20'hFFFFF;
        end
    do_run("maxpos", -1, -1);
    check("maxpos_l1k0_5",   64'(l1[0][5]),   64'hFFFFF);
    check("maxpos_l1k1_6",   64'(l1[1][6]),   64'hFFFFF);
    check("maxpos_l2f_2047", 64'(l2f[2047]),  64'hFFFFF);

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NPIX; i++) l0[k][i] = DW'($urandom);
    do_run("abort", -1, 3000);
    do_run("rerun", -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
